// File: rtl/task_scheduler_pkg.sv
// rtl/task_scheduler_pkg.sv - shared widths, entry packing and helpers for the next-task scheduler
package task_scheduler_pkg;

    localparam int CHAN_W = 3;
    localparam int THR_W  = 2;
    localparam int IDX_W  = CHAN_W + THR_W;
    localparam int N_ENT  = 1 << IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } sched_state_t;

    // Entry index is {channel, thread}; ifetch decodes offers the same way.
    function automatic logic [IDX_W-1:0] pack_idx(input logic [CHAN_W-1:0] chan,
                                                  input logic [THR_W-1:0]  thr);
        return {chan, thr};
    endfunction

    function automatic logic [CHAN_W-1:0] idx_chan(input logic [IDX_W-1:0] idx);
        return idx[IDX_W-1:THR_W];
    endfunction

    function automatic logic [THR_W-1:0] idx_thr(input logic [IDX_W-1:0] idx);
        return idx[THR_W-1:0];
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [N_ENT-1:0] vec);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < N_ENT; i++) begin
            n = n + {{IDX_W{1'b0}}, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/task_scheduler_rr_pick.sv
// rtl/task_scheduler_rr_pick.sv - round-robin picker: first set request strictly after the pointer
module rr_pick
    import task_scheduler_pkg::*;
(
    input  logic [N_ENT-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_ENT-1:0] doubled;
    logic [N_ENT-1:0]   rotated;
    logic [IDX_W-1:0]   start;
    logic [IDX_W-1:0]   offset;

    // Rotate so the slot after ptr sits at bit 0, take the lowest set bit, then rotate back.
    // Search starts at ptr+1, so a lone request at ptr is found last (full circle).
    always_comb begin
        start   = ptr + IDX_W'(1);
        doubled = {req, req} >> start;
        rotated = doubled[N_ENT-1:0];
        found   = 1'b0;
        offset  = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = IDX_W'(i);
            end
        end
        idx = start + offset;
    end

endmodule

// File: rtl/task_scheduler.sv
// rtl/task_scheduler.sv - pending wake bitmap with round-robin next-task offer handshake
module task_scheduler
    import task_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wake_valid,
    input  logic [CHAN_W-1:0] wake_channel,
    input  logic [THR_W-1:0]  wake_thread,
    input  logic              cancel_valid,
    input  logic [CHAN_W-1:0] cancel_channel,
    input  logic [THR_W-1:0]  cancel_thread,
    output logic              next_task_ready,
    output logic [CHAN_W-1:0] next_task_channel,
    output logic [THR_W-1:0]  next_task_thread,
    input  logic              next_task_ack,
    output logic              cancel_busy,
    output logic [IDX_W:0]    pending_count
);

    sched_state_t     state, state_nx;
    logic [N_ENT-1:0] pending, pending_nx;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nx;
    logic [IDX_W-1:0] offer_idx, offer_idx_nx;
    logic             wake_q;
    logic [IDX_W-1:0] wake_q_idx;
    logic [IDX_W-1:0] cancel_idx;
    logic             cancel_hits_offer;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    rr_pick u_rr_pick (
        .req   (pending),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cancel_idx        = pack_idx(cancel_channel, cancel_thread);
    assign cancel_hits_offer = cancel_valid && (state == ST_OFFER) && (cancel_idx == offer_idx);

    assign next_task_ready   = (state == ST_OFFER);
    assign next_task_channel = idx_chan(offer_idx);
    assign next_task_thread  = idx_thr(offer_idx);

    // Offer FSM: IDLE registers the round-robin pick, OFFER holds it until ack and moves the pointer.
    always_comb begin
        state_nx     = state;
        offer_idx_nx = offer_idx;
        rr_ptr_nx    = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nx     = ST_OFFER;
                    offer_idx_nx = pick_idx;
                end
            end
            ST_OFFER: begin
                if (next_task_ack) begin
                    state_nx  = ST_IDLE;
                    rr_ptr_nx = offer_idx;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Bitmap update: retire on ack, then cancel, then the staged wake, so a wake always wins.
    always_comb begin
        pending_nx = pending;
        if ((state == ST_OFFER) && next_task_ack) begin
            pending_nx[offer_idx] = 1'b0;
        end
        if (cancel_valid && !cancel_hits_offer) begin
            pending_nx[cancel_idx] = 1'b0;
        end
        if (wake_q) begin
            pending_nx[wake_q_idx] = 1'b1;
        end
    end

    // State, bitmap, wake staging and status registers; reset drops any live offer at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            pending       <= '0;
            rr_ptr        <= IDX_W'(N_ENT - 1);
            offer_idx     <= '0;
            wake_q        <= 1'b0;
            wake_q_idx    <= '0;
            cancel_busy   <= 1'b0;
            pending_count <= '0;
        end else begin
            state         <= state_nx;
            pending       <= pending_nx;
            rr_ptr        <= rr_ptr_nx;
            offer_idx     <= offer_idx_nx;
            wake_q        <= wake_valid;
            wake_q_idx    <= pack_idx(wake_channel, wake_thread);
            cancel_busy   <= cancel_hits_offer;
            pending_count <= popcount(pending_nx);
        end
    end

endmodule

// File: tb/tb_task_scheduler.sv
// tb/tb_task_scheduler.sv - randomized and directed bench for task_scheduler against a queue-level model
module tb_task_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wake_valid;
    logic [2:0] wake_channel;
    logic [1:0] wake_thread;
    logic       cancel_valid;
    logic [2:0] cancel_channel;
    logic [1:0] cancel_thread;
    logic       next_task_ready;
    logic [2:0] next_task_channel;
    logic [1:0] next_task_thread;
    logic       next_task_ack;
    logic       cancel_busy;
    logic [5:0] pending_count;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;
    int acc[$];

    // model state
    bit m_pend[32];
    int m_ptr;
    bit m_off;
    int m_idx;
    bit m_busy;
    bit m_wq;
    int m_wqi;
    int m_cnt;

    task_scheduler dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .wake_valid        (wake_valid),
        .wake_channel      (wake_channel),
        .wake_thread       (wake_thread),
        .cancel_valid      (cancel_valid),
        .cancel_channel    (cancel_channel),
        .cancel_thread     (cancel_thread),
        .next_task_ready   (next_task_ready),
        .next_task_channel (next_task_channel),
        .next_task_thread  (next_task_thread),
        .next_task_ack     (next_task_ack),
        .cancel_busy       (cancel_busy),
        .pending_count     (pending_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_ptr  = 31;
        m_off  = 1'b0;
        m_idx  = 0;
        m_busy = 1'b0;
        m_wq   = 1'b0;
        m_wqi  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        bit np[32];
        int nptr;
        bit noff;
        int nidx;
        bit nbusy;
        int ci;
        bit got;
        np    = m_pend;
        nptr  = m_ptr;
        noff  = m_off;
        nidx  = m_idx;
        nbusy = 1'b0;
        if (m_off) begin
            if (next_task_ack) begin
                np[m_idx] = 1'b0;
                nptr      = m_idx;
                noff      = 1'b0;
            end
        end else begin
            got = 1'b0;
            for (int k = 1; k <= 32; k++) begin
                if (!got && m_pend[(m_ptr + k) % 32]) begin
                    got  = 1'b1;
                    noff = 1'b1;
                    nidx = (m_ptr + k) % 32;
                end
            end
        end
        if (cancel_valid) begin
            ci = int'(cancel_channel) * 4 + int'(cancel_thread);
            if (m_off && ci == m_idx) nbusy = 1'b1;
            else np[ci] = 1'b0;
        end
        if (m_wq) np[m_wqi] = 1'b1;
        m_wq   = wake_valid;
        m_wqi  = int'(wake_channel) * 4 + int'(wake_thread);
        m_pend = np;
        m_ptr  = nptr;
        m_off  = noff;
        m_idx  = nidx;
        m_busy = nbusy;
        m_cnt  = 0;
        foreach (np[i]) m_cnt += int'(np[i]);
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_clear();
            else model_step();
        end
    end

    // Compare every cycle at the falling edge; also log accepted offers.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                check("ready", int'(next_task_ready), int'(m_off));
                check("channel", int'(next_task_channel), m_idx / 4);
                check("thread", int'(next_task_thread), m_idx % 4);
                check("cancel_busy", int'(cancel_busy), int'(m_busy));
                check("pending_count", int'(pending_count), m_cnt);
                if (reset_n && next_task_ready && next_task_ack)
                    acc.push_back(int'(next_task_channel) * 4 + int'(next_task_thread));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wake(input int ch, input int th);
        wake_valid   = 1'b1;
        wake_channel = 3'(ch);
        wake_thread  = 2'(th);
    endtask

    task automatic set_cancel(input int ch, input int th);
        cancel_valid   = 1'b1;
        cancel_channel = 3'(ch);
        cancel_thread  = 2'(th);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!next_task_ready && n < 10) begin
            cyc();
            n++;
        end
        check("wait_ready", int'(next_task_ready), 1);
    endtask

    initial begin
        reset_n = 1'b0;
        wake_valid = 1'b0; wake_channel = '0; wake_thread = '0;
        cancel_valid = 1'b0; cancel_channel = '0; cancel_thread = '0;
        next_task_ack = 1'b0;
        repeat (3) cyc();
        cmp_on = 1'b1;
        reset_n = 1'b1;

        repeat (4) cyc();
        check("idle_ready", int'(next_task_ready), 0);
        check("idle_count", int'(pending_count), 0);

        // single wake latency, held offer, and three wakes queued behind it
        set_wake(7, 0); cyc();
        check("lat_n0_ready", int'(next_task_ready), 0);
        set_wake(2, 1); cyc();
        check("lat_n1_ready", int'(next_task_ready), 0);
        check("lat_n1_count", int'(pending_count), 1);
        set_wake(0, 3); cyc();
        check("lat_n2_ready", int'(next_task_ready), 1);
        check("lat_n2_channel", int'(next_task_channel), 7);
        check("lat_n2_thread", int'(next_task_thread), 0);
        set_wake(5, 2); cyc();
        wake_valid = 1'b0;
        cyc(); cyc();
        check("hold_channel", int'(next_task_channel), 7);
        check("hold_count", int'(pending_count), 4);
        acc.delete();
        next_task_ack = 1'b1; cyc();
        check("ack_ready_low", int'(next_task_ready), 0);
        check("ack_count", int'(pending_count), 3);
        repeat (8) cyc();
        next_task_ack = 1'b0;
        check("rr_order_len", acc.size(), 4);
        if (acc.size() == 4) begin
            check("rr_order0", acc[0], 28);
            check("rr_order1", acc[1], 3);
            check("rr_order2", acc[2], 9);
            check("rr_order3", acc[3], 22);
        end

        // cancel of offered entry is refused; cancel of a merely pending entry clears it
        set_wake(3, 3); cyc();
        set_wake(4, 0); cyc();
        wake_valid = 1'b0;
        wait_ready();
        check("cb_offer_channel", int'(next_task_channel), 3);
        set_cancel(3, 3); cyc();
        cancel_valid = 1'b0;
        check("cb_busy", int'(cancel_busy), 1);
        check("cb_ready", int'(next_task_ready), 1);
        check("cb_thread", int'(next_task_thread), 3);
        set_cancel(4, 0); cyc();
        cancel_valid = 1'b0;
        check("cb_busy_clear", int'(cancel_busy), 0);
        check("cancel_count", int'(pending_count), 1);
        acc.delete();
        next_task_ack = 1'b1;
        repeat (6) cyc();
        next_task_ack = 1'b0;
        check("cancel_offers", acc.size(), 1);
        if (acc.size() == 1) check("cancel_offer0", acc[0], 15);
        check("cancel_final_count", int'(pending_count), 0);

        // same-edge wake and cancel, then re-wake on the ack edge
        set_wake(1, 1); set_cancel(1, 1); cyc();
        wake_valid = 1'b0; cancel_valid = 1'b0;
        cyc();
        check("wc_count", int'(pending_count), 1);
        wait_ready();
        check("wc_channel", int'(next_task_channel), 1);
        set_wake(6, 1); cyc();
        wake_valid = 1'b0;
        cyc();
        acc.delete();
        next_task_ack = 1'b1; set_wake(1, 1); cyc();
        wake_valid = 1'b0;
        repeat (8) cyc();
        next_task_ack = 1'b0;
        check("rewake_len", acc.size(), 3);
        if (acc.size() == 3) begin
            check("rewake0", acc[0], 5);
            check("rewake1", acc[1], 25);
            check("rewake2", acc[2], 5);
        end

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            wake_valid     = ($urandom_range(2) == 0);
            wake_channel   = 3'($urandom_range(7));
            wake_thread    = 2'($urandom_range(3));
            cancel_valid   = ($urandom_range(4) == 0);
            cancel_channel = 3'($urandom_range(7));
            cancel_thread  = 2'($urandom_range(3));
            next_task_ack  = ($urandom_range(1) == 0);
            cyc();
        end
        wake_valid = 1'b0; cancel_valid = 1'b0; next_task_ack = 1'b0;

        // asynchronous reset in the middle of an offer
        set_wake(2, 2); cyc();
        set_wake(6, 3); cyc();
        wake_valid = 1'b0;
        wait_ready();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_ready", int'(next_task_ready), 0);
        check("async_rst_count", int'(pending_count), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next_task_ack = 1'($urandom_range(1));
            cyc();
        end
        next_task_ack = 1'b0;
        check("post_rst_ready", int'(next_task_ready), 0);
        check("post_rst_count", int'(pending_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
